// File: rtl/scan_ctrl.sv
// Scan controller: walks element/line/window counters for one scan per start request.
// Optional stall cycle counter enabled by defining SCAN_STALL_CNT_EN.
module scan_ctrl #(
  parameter int DATA_LAST = 63,
  parameter int LINE_LAST = 15,
  parameter int WIND_LAST = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        dat_ready,
  output logic        dat_valid,
  output logic [5:0]  count_data,
  output logic [3:0]  count_line,
  output logic [1:0]  count_wind,
  output logic [2:0]  state,
  output logic        busy,
  output logic        done
`ifdef SCAN_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DATA = 3'd1,
    LINE = 3'd2,
    WIND = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [5:0] DATA_MAX = 6'(DATA_LAST);
  localparam logic [3:0] LINE_MAX = 4'(LINE_LAST);
  localparam logic [1:0] WIND_MAX = 2'(WIND_LAST);

  state_t     state_q, state_d;
  logic [5:0] data_q, data_d;
  logic [3:0] line_q, line_d;
  logic [1:0] wind_q, wind_d;
  logic       start_ok;
  logic       abort_ok;

  assign start_ok = (state_q == IDLE) && start && !abort;
  assign abort_ok = (state_q != IDLE) && abort;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    state_d = state_q;
    data_d  = data_q;
    line_d  = line_q;
    wind_d  = wind_q;
    case (state_q)
      IDLE: if (start_ok) begin
        state_d = DATA;
        data_d  = '0;
        line_d  = '0;
        wind_d  = '0;
      end
      DATA: if (dat_ready) begin
        if (data_q < DATA_MAX) data_d = data_q + 6'd1;
        else                   state_d = LINE;
      end
      LINE: if (line_q < LINE_MAX) begin
        line_d  = line_q + 4'd1;
        data_d  = '0;
        state_d = DATA;
      end else begin
        state_d = WIND;
      end
      WIND: if (wind_q < WIND_MAX) begin
        wind_d  = wind_q + 2'd1;
        line_d  = '0;
        data_d  = '0;
        state_d = DATA;
      end else begin
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        data_d  = '0;
        line_d  = '0;
        wind_d  = '0;
      end
    endcase
    // Abort overrides everything decided above, including a pending done.
    if (abort_ok) begin
      state_d = IDLE;
      data_d  = '0;
      line_d  = '0;
      wind_d  = '0;
    end
  end

  // NOTE: reset is tested inside the clocked block, so it only acts on a rising edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      line_q  <= '0;
      wind_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from the same old values.
      state_q <= state_d;
      data_q  <= data_d;
      line_q  <= line_d;
      wind_q  <= wind_d;
    end
  end

  assign state      = state_q;
  assign busy       = (state_q != IDLE);
  assign dat_valid  = (state_q == DATA);
  assign done       = (state_q == DONE) && !abort;
  assign count_data = data_q;
  assign count_line = line_q;
  assign count_wind = wind_q;

`ifdef SCAN_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (start_ok || abort_ok) begin
      stall_q <= '0;
    end else if ((state_q == DATA) && !dat_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_scan_ctrl.sv
// Directed bench for scan_ctrl: a small-parameter instance (3/1/1) and a default instance.
module tb_scan_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic start_s, abort_s, ready_s;
  logic start_d, abort_d, ready_d;

  logic       valid_s, busy_s, done_s;
  logic [5:0] data_s;
  logic [3:0] line_s;
  logic [1:0] wind_s;
  logic [2:0] state_s;
  logic       valid_d, busy_d, done_d;
  logic [5:0] data_d;
  logic [3:0] line_d;
  logic [1:0] wind_d;
  logic [2:0] state_d;
`ifdef SCAN_STALL_CNT_EN
  logic [15:0] stall_s, stall_d;
`endif

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;
  int cyc;
  int nvalid;
  int pulses_before;

  always #5 clk = ~clk;

  scan_ctrl #(.DATA_LAST(3), .LINE_LAST(1), .WIND_LAST(1)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .abort(abort_s), .dat_ready(ready_s),
    .dat_valid(valid_s), .count_data(data_s), .count_line(line_s), .count_wind(wind_s),
    .state(state_s), .busy(busy_s), .done(done_s)
`ifdef SCAN_STALL_CNT_EN
    , .stall_cnt(stall_s)
`endif
  );

  scan_ctrl dut_d (
    .clk(clk), .reset(reset), .start(start_d), .abort(abort_d), .dat_ready(ready_d),
    .dat_valid(valid_d), .count_data(data_d), .count_line(line_d), .count_wind(wind_d),
    .state(state_d), .busy(busy_d), .done(done_d)
`ifdef SCAN_STALL_CNT_EN
    , .stall_cnt(stall_d)
`endif
  );

  always @(negedge clk) if (done_s) done_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Start the small instance and return in cycle 0 (first DATA cycle).
  task automatic kick_small();
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
  endtask

  task automatic wait_small_done(input int bound, inout int c);
    while (!done_s && c < bound) begin
      tick();
      c++;
    end
  endtask

  initial begin
    reset = 1'b0;
    start_s = 1'b0; abort_s = 1'b0; ready_s = 1'b1;
    start_d = 1'b0; abort_d = 1'b0; ready_d = 1'b1;
    repeat (2) tick();

    // Reset state
    check("rst_state", state_s, 0);
    check("rst_data", data_s, 0);
    check("rst_line", line_s, 0);
    check("rst_wind", wind_s, 0);
    check("rst_busy", busy_s, 0);
    check("rst_done", done_s, 0);
    check("rst_valid", valid_s, 0);
`ifdef SCAN_STALL_CNT_EN
    check("rst_stall", stall_s, 0);
`endif
    reset = 1'b1;
    tick();

    // Abort beats start in IDLE
    start_s = 1'b1; abort_s = 1'b1;
    tick();
    start_s = 1'b0; abort_s = 1'b0;
    check("idle_abort_start_state", state_s, 0);

    // Full scan: 16 elements in ascending order, done 22 cycles after start edge
    pulses_before = done_pulses;
    kick_small();
    cyc = 0;
    nvalid = 0;
    while (!done_s && cyc < 100) begin
      if (valid_s) begin
        check($sformatf("seq_%0d", nvalid), {wind_s, line_s, data_s},
              {2'(nvalid / 8), 4'((nvalid / 4) % 2), 6'(nvalid % 4)});
        nvalid++;
      end
      tick();
      cyc++;
    end
    check("full_cycles", cyc, 22);
    check("full_nvalid", nvalid, 16);
    check("full_done_state", state_s, 4);
    check("full_done_busy", busy_s, 1);
    check("full_final", {wind_s, line_s, data_s}, {2'd1, 4'd1, 6'd3});
    tick();
    check("full_done_low", done_s, 0);
    check("full_idle", state_s, 0);
    check("full_counters_hold", {wind_s, line_s, data_s}, {2'd1, 4'd1, 6'd3});
    check("full_pulses", done_pulses - pulses_before, 1);

    // Reset mid-DATA for two cycles
    pulses_before = done_pulses;
    kick_small();
    repeat (3) tick();
    check("mid_data_state", state_s, 1);
    reset = 1'b0;
    tick();
    check("mid_rst_state", state_s, 0);
    tick();
    reset = 1'b1;
    check("mid_rst_counts", {wind_s, line_s, data_s}, 0);
    check("mid_rst_busy", busy_s, 0);
    repeat (3) tick();
    check("mid_rst_stays_idle", state_s, 0);
    check("mid_rst_no_done", done_pulses - pulses_before, 0);

    // Backpressure: dat_ready low 5 cycles at count_data=2
    kick_small();
    cyc = 0;
    repeat (2) begin tick(); cyc++; end
    check("bp_at_data2", data_s, 2);
    ready_s = 1'b0;
    repeat (5) begin tick(); cyc++; end
    check("bp_hold_data", data_s, 2);
    check("bp_hold_state", state_s, 1);
    ready_s = 1'b1;
    wait_small_done(100, cyc);
    check("bp_cycles", cyc, 27);
`ifdef SCAN_STALL_CNT_EN
    check("bp_stall_cnt", stall_s, 5);
`endif
    tick();

    // Abort while count_line=1, then a clean full scan
    pulses_before = done_pulses;
    kick_small();
    repeat (6) tick();
    check("ab_line1", line_s, 1);
    abort_s = 1'b1;
    tick();
    abort_s = 1'b0;
    check("ab_state", state_s, 0);
    check("ab_counts", {wind_s, line_s, data_s}, 0);
    check("ab_done", done_s, 0);
`ifdef SCAN_STALL_CNT_EN
    check("ab_stall_clear", stall_s, 0);
`endif
    tick();
    kick_small();
    cyc = 0;
    wait_small_done(100, cyc);
    check("ab_rescan_cycles", cyc, 22);
    tick();
    check("ab_pulses", done_pulses - pulses_before, 1);

    // Start while busy is ignored
    pulses_before = done_pulses;
    kick_small();
    cyc = 0;
    tick(); cyc++;
    check("sb_data1", data_s, 1);
    start_s = 1'b1;
    tick(); cyc++;
    start_s = 1'b0;
    check("sb_not_restarted", data_s, 2);
    wait_small_done(100, cyc);
    check("sb_cycles", cyc, 22);
    repeat (30) tick();
    check("sb_pulses", done_pulses - pulses_before, 1);
    check("sb_idle", state_s, 0);

    // Default parameters: 4164-cycle scan
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    cyc = 0;
    while (!done_d && cyc < 5000) begin
      tick();
      cyc++;
    end
    check("def_cycles", cyc, 4164);
    check("def_final", {wind_d, line_d, data_d}, {2'd3, 4'd15, 6'd63});
    tick();
    check("def_idle", state_d, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_ctrl.md
SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 Parameter DATA_LAST, default 63, last count_data value per line (legal 1..63).
REQ-002 Parameter LINE_LAST, default 15, last count_line value per window (legal 1..15).
REQ-003 Parameter WIND_LAST, default 3, last count_wind value per scan (legal 1..3).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 start  input  1  request one full scan; sampled only in IDLE.
REQ-007 abort  input  1  terminate the scan in progress.
REQ-008 dat_ready  input  1  datapath accepts the current element.
REQ-009 dat_valid  output  1  current count_data/count_line/count_wind form a valid element.
REQ-010 count_data  output  6  element index within line.
REQ-011 count_line  output  4  line index within window.
REQ-012 count_wind  output  2  window index within scan.
REQ-013 state  output  3  current state encoding.
REQ-014 busy  output  1  high whenever state != IDLE.
REQ-015 done  output  1  one-cycle pulse at scan completion.
REQ-016 stall_cnt  output  16  stall cycle count; present only with SCAN_STALL_CNT_EN.

Function
REQ-017 States SHALL be IDLE=3'd0, DATA=3'd1, LINE=3'd2, WIND=3'd3, DONE=3'd4; other encodings SHALL go to IDLE next cycle.
REQ-018 IDLE: start=1 and abort=0 -> DATA, all counters cleared to 0; otherwise hold.
REQ-019 DATA: dat_valid=1 (combinational from state); counters hold while dat_ready=0.
REQ-020 DATA, dat_ready=1: count_data<DATA_LAST -> count_data+1, stay DATA; count_data==DATA_LAST -> LINE, count_data held.
REQ-021 LINE (one cycle, dat_valid=0): count_line<LINE_LAST -> count_line+1, count_data<=0, DATA; else -> WIND, counters held.
REQ-022 WIND (one cycle, dat_valid=0): count_wind<WIND_LAST -> count_wind+1, count_line<=0, count_data<=0, DATA; else -> DONE.
REQ-023 DONE: done=1 for exactly that cycle, counters hold final values, next state IDLE.
REQ-024 abort=1 in DATA/LINE/WIND/DONE SHALL force IDLE next cycle, clear counters, suppress done; abort has priority over every other transition and over start.
REQ-025 start while busy SHALL be ignored (no queuing).
REQ-026 Counters SHALL never exceed their *_LAST values; no wrap-around within a scan.
REQ-027 With dat_ready held high, scan length from start edge to DONE entry SHALL be (WIND_LAST+1)*((LINE_LAST+1)*(DATA_LAST+2)+1) cycles (4164 for defaults).
REQ-028 dat_valid SHALL be 0 in every state except DATA.

Reset
REQ-029 reset=0 at a rising edge SHALL set state=IDLE, count_data=0, count_line=0, count_wind=0, stall_cnt=0; busy=0, done=0, dat_valid=0 follow.
REQ-030 Reset mid-scan SHALL take effect on the next edge with no done pulse; reset has priority over abort and start.

Configuration
REQ-031 Macro SCAN_STALL_CNT_EN defined: stall_cnt increments each cycle with state==DATA and dat_ready=0, saturates at 16'hFFFF, clears on accepted start, abort, and reset.
REQ-032 Macro SCAN_STALL_CNT_EN undefined: stall_cnt port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-033 Reset: reset=0 two cycles mid-DATA -> state=0, all counts 0, busy=0, done never pulses.
REQ-034 Full scan, DATA_LAST=3, LINE_LAST=1, WIND_LAST=1, dat_ready=1: done pulses once, 22 cycles after start edge; 16 dat_valid cycles, indices in (wind,line,data) ascending order.
REQ-035 Backpressure: same params, dat_ready low 5 cycles at count_data=2 -> counters hold, done delayed by exactly 5 cycles, stall_cnt=5 (macro on).
REQ-036 Abort: abort=1 while count_line=1 -> IDLE next cycle, counts 0, done=0; new start then runs full 22-cycle scan.
REQ-037 Start while busy: second start pulse at count_data=1 -> ignored, exactly one done.
REQ-038 Defaults, dat_ready=1: done 4164 cycles after start; final count_data=63, count_line=15, count_wind=3.
